id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter BUS_IN_W, 64, width of fetch-to-decode bus {pc[63:32], inst[31:0]}.
REQ-002 Parameter BUS_OUT_W, 144, width of decode-to-execute bus.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  fetch bus holds a valid instruction.
REQ-006 in_ready  output  1  decode accepts in_bus this cycle.
REQ-007 in_bus  input  64  {pc, inst} from fetch.
REQ-008 out_valid  output  1  out_bus holds a decoded instruction.
REQ-009 out_ready  input  1  execute accepts out_bus this cycle.
REQ-010 out_bus  output  144  pc[143:112], rs1_data[111:80], rs2_data[79:48], imm[47:16], rd[15:11], alu_op[10:7], reg_we[6], mem_re[5], mem_we[4], branch[3], jump[2], src_b_imm[1], illegal[0].
REQ-011 wb_we  input  1  writeback enable.
REQ-012 wb_addr  input  5  writeback register index.
REQ-013 wb_data  input  32  writeback value.

Function
REQ-014 Single pipeline register; in_ready SHALL equal ~out_valid | out_ready (combinational).
REQ-015 Capture when in_valid & in_ready: out_bus loads decoded fields next edge, out_valid set 1; latency exactly one cycle.
REQ-016 Output fire (out_valid & out_ready) with no capture: out_valid cleared next edge.
REQ-017 out_valid & ~out_ready: out_bus and out_valid held bit-stable.
REQ-018 Decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode or invalid funct3/funct7 sets illegal=1 with reg_we=mem_re=mem_we=branch=jump=0.
REQ-019 imm per I/S/B/U/J format, sign-extended to 32 bits; R-type imm=0.
REQ-020 alu_op: ADD for LUI/AUIPC/JAL/JALR/LOAD/STORE/ADDI/ADD; SUB for branches and SUB; others per funct3/funct7 from package encoding.
REQ-021 reg_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; forced 0 when rd=0.
REQ-022 src_b_imm=1 for all but OP and BRANCH.
REQ-023 rs1_data/rs2_data read from 32x32 register file using inst[19:15]/inst[24:20] at capture; x0 reads 0.
REQ-024 Register write on wb_we when wb_addr!=0; wb_we with wb_addr=0 ignored.
REQ-025 Same-cycle write and capture read of same nonzero index SHALL return wb_data (write-through bypass).

Reset
REQ-026 Reset clears out_valid to 0 and out_bus to 0; in_ready=1 the cycle after reset.
REQ-027 Reset clears all 31 writable registers to 0; reset overrides simultaneous capture or writeback.

Structure
REQ-028 Shared package holds alu_op encoding (ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9), RV32I opcode constants, bus field offsets.
REQ-029 Register file is one sub-module, regfile: two async read ports, one sync write port, bypass per REQ-025.

Verification
REQ-030 in_bus={0x00000010,0x00500093}, out_ready=1 -> next cycle out_valid=1, pc=0x10, rd=1, imm=5, alu_op=0, reg_we=1, src_b_imm=1, illegal=0.
REQ-031 out_ready=0 with out_valid=1 and new in_valid -> in_ready=0, out_bus unchanged for 5 cycles; out_ready=1 -> next bus accepted one cycle later.
REQ-032 wb_we=1, wb_addr=2, wb_data=0xDEADBEEF same cycle as capturing 0x000101B3 -> rs1_data=0xDEADBEEF, rd=3.
REQ-033 wb_we=1, wb_addr=0, wb_data=0x12345678, then decode 0x00000033 -> rs1_data=rs2_data=0, reg_we=0.
REQ-034 inst=0xFFFFFFFF -> illegal=1, reg_we=mem_re=mem_we=branch=jump=0; inst=0xFE000EE3 (beq, offset -4) -> branch=1, imm=0xFFFFFFFC.
REQ-035 Assert reset while out_valid=1, out_ready=0 -> next cycle out_valid=0, out_bus=0, in_ready=1, reads of x1..x31 return 0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the RV32I decode stage: ALU op codes, opcodes,
// and the layout of the decode-to-execute bus.
package id_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Bit offsets of the fields inside the decode-to-execute bus.
  localparam int OFS_PC        = 112;
  localparam int OFS_RS1       = 80;
  localparam int OFS_RS2       = 48;
  localparam int OFS_IMM       = 16;
  localparam int OFS_RD        = 11;
  localparam int OFS_ALU       = 7;
  localparam int BIT_REG_WE    = 6;
  localparam int BIT_MEM_RE    = 5;
  localparam int BIT_MEM_WE    = 4;
  localparam int BIT_BRANCH    = 3;
  localparam int BIT_JUMP      = 2;
  localparam int BIT_SRC_B_IMM = 1;
  localparam int BIT_ILLEGAL   = 0;

  // Packed so that the struct bit positions match the offsets above.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    alu_op_t         alu_op;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jump;
    logic            src_b_imm;
    logic            illegal;
  } dec_t;

  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file: two async read ports, one sync write port,
// with write-through so a same-cycle write is visible on the read ports.
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];
  logic            wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0)             ? '0    :
                  (wr_en && waddr == raddr1)   ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0)             ? '0    :
                  (wr_en && waddr == raddr2)   ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetch bus, reads operands and holds the result
// in a single valid/ready pipeline register towards execute.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int BUS_IN_W  = 64,
  parameter int BUS_OUT_W = 144
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_IN_W-1:0]  in_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_OUT_W-1:0] out_bus,
  input  logic                 wb_we,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data
);

  logic [XLEN-1:0] pc, inst, rs1_data, rs2_data;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]      opc, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            legal, we_raw, capture;
  dec_t            dec, out_q;

  assign pc     = in_bus[63:32];
  assign inst   = in_bus[31:0];
  assign opc    = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  id_stage_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (inst[19:15]),
    .raddr2 (inst[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  always_comb begin
    dec           = '0;
    dec.pc        = pc;
    dec.rs1_data  = rs1_data;
    dec.rs2_data  = rs2_data;
    dec.rd        = rd;
    dec.alu_op    = ALU_ADD;
    dec.src_b_imm = !(opc == OPC_OP || opc == OPC_BRANCH);
    legal         = 1'b1;
    we_raw        = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = imm_u;
        we_raw  = 1'b1;
      end
      OPC_JAL: begin
        dec.imm  = imm_j;
        we_raw   = 1'b1;
        dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.imm  = imm_i;
        we_raw   = 1'b1;
        dec.jump = 1'b1;
        legal    = (funct3 == 3'd0);
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        legal      = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_LOAD: begin
        dec.imm    = imm_i;
        we_raw     = 1'b1;
        dec.mem_re = 1'b1;
        legal      = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OPC_STORE: begin
        dec.imm    = imm_s;
        dec.mem_we = 1'b1;
        legal      = (funct3 <= 3'd2);
      end
      OPC_OP_IMM: begin
        dec.imm    = imm_i;
        we_raw     = 1'b1;
        // Only shifts carry funct7 in the immediate; SRAI is the one alternate form.
        dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'd5) && (funct7 == FUNCT7_ALT));
        if (funct3 == 3'd1)      legal = (funct7 == FUNCT7_BASE);
        else if (funct3 == 3'd5) legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
      end
      OPC_OP: begin
        we_raw     = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, funct7 == FUNCT7_ALT);
        legal      = (funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_ALT) && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.imm    = '0;
      dec.alu_op = ALU_ADD;
      we_raw     = 1'b0;
      dec.mem_re = 1'b0;
      dec.mem_we = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
    dec.reg_we  = we_raw && (rd != 5'd0);
    dec.illegal = !legal;
  end

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_bus = out_q;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a behavioural RV32I decode model,
// plus directed cases for the handshake, bypass, illegal and reset behaviour.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_bus;
  logic         out_valid;
  logic         out_ready;
  logic [143:0] out_bus;
  logic         wb_we;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;

  id_stage #(.BUS_IN_W(64), .BUS_OUT_W(144)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic         m_valid = 1'b0;
  logic [143:0] m_bus = '0;
  logic [31:0]  m_regs [32];

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] ref_decode(input logic [63:0] bus, input bit wwe,
                                              input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] inst, pc, imm, v1, v2;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, r1, r2;
    logic [3:0]  alu;
    logic [3:0]  alu_tab [8];
    bit          ok, we, mre, mwe, br, jp;
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    pc = bus[63:32];
    inst = bus[31:0];
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    rd = inst[11:7]; r1 = inst[19:15]; r2 = inst[24:20];
    v1 = (r1 == 0) ? 32'd0 : (wwe && wa == r1) ? wd : m_regs[r1];
    v2 = (r2 == 0) ? 32'd0 : (wwe && wa == r2) ? wd : m_regs[r2];
    ok = 1; we = 0; mre = 0; mwe = 0; br = 0; jp = 0; imm = 0; alu = 0;
    case (op)
      7'h37, 7'h17: begin imm = inst & 32'hFFFF_F000; we = 1; end
      7'h6F: begin
        imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 12'b0}) >>> 11;
        we = 1; jp = 1;
      end
      7'h67: begin imm = $signed(inst) >>> 20; we = 1; jp = 1; ok = (f3 == 0); end
      7'h63: begin
        imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 20'b0}) >>> 19;
        br = 1; alu = 1; ok = !(f3 == 2 || f3 == 3);
      end
      7'h03: begin imm = $signed(inst) >>> 20; we = 1; mre = 1; ok = (f3 != 3 && f3 < 6); end
      7'h23: begin imm = $signed({inst[31:25], inst[11:7], 20'b0}) >>> 20; mwe = 1; ok = (f3 < 3); end
      7'h13: begin
        imm = $signed(inst) >>> 20; we = 1; alu = alu_tab[f3];
        if (f3 == 5 && f7 == 7'h20) alu = 7;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        we = 1; alu = alu_tab[f3];
        if (f7 == 7'h20) alu = (f3 == 0) ? 4'd1 : 4'd7;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      default: ok = 0;
    endcase
    if (!ok) begin imm = 0; alu = 0; we = 0; mre = 0; mwe = 0; br = 0; jp = 0; end
    if (rd == 0) we = 0;
    return {pc, v1, v2, imm, rd, alu, we, mre, mwe, br, jp, !(op == 7'h33 || op == 7'h63), !ok};
  endfunction

  // Drives one clock cycle (call just after a falling edge) and checks the result.
  task automatic cycle(input bit rst, input bit iv, input bit ordy, input bit wwe,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [63:0] bus);
    logic exp_rdy;
    reset = rst; in_valid = iv; out_ready = ordy;
    wb_we = wwe; wb_addr = wa; wb_data = wd; in_bus = bus;
    #1;
    exp_rdy = !m_valid || ordy;
    if (!rst) check("in_ready", {143'd0, in_ready}, {143'd0, exp_rdy});
    if (rst) begin
      m_valid = 0;
      m_bus = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (iv && exp_rdy) begin
        m_bus = ref_decode(bus, wwe, wa, wd);
        m_valid = 1;
      end else if (ordy) begin
        m_valid = 0;
      end
      if (wwe && wa != 0) m_regs[wa] = wd;
    end
    @(negedge clk);
    check("out_valid", {143'd0, out_valid}, {143'd0, m_valid});
    if (m_valid || rst) check("out_bus", out_bus, m_bus);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] inst;
    logic [6:0]  ops [9];
    int          k, r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    inst = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) inst[6:0] = ops[k];
    r = $urandom_range(0, 3);
    if (r == 0 || r == 2) inst[31:25] = 7'h00;
    else if (r == 1) inst[31:25] = 7'h20;
    return inst;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] inst;
    reset = 1; in_valid = 0; out_ready = 0; wb_we = 0; wb_addr = 0; wb_data = 0; in_bus = 0;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // addi x1, x0, 5 at pc 0x10
    cycle(0, 1, 1, 0, 0, 0, {32'h10, 32'h0050_0093});
    check("addi_pc", out_bus[143:112], 32'h10);
    check("addi_rd", out_bus[15:11], 5'd1);
    check("addi_imm", out_bus[47:16], 32'd5);
    check("addi_alu", out_bus[10:7], 4'd0);
    check("addi_flags", {out_bus[6], out_bus[1], out_bus[0]}, 3'b110);

    // stall: new input presented while execute holds off
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0, 0, 0, {32'h20, 32'h0000_0033});
      check("stall_in_ready", {143'd0, in_ready}, 144'd0);
      check("stall_pc", out_bus[143:112], 32'h10);
    end
    cycle(0, 1, 1, 0, 0, 0, {32'h20, 32'h0000_0033});
    check("release_pc", out_bus[143:112], 32'h20);

    // write-through bypass on rs1 = x2
    cycle(0, 1, 1, 1, 5'd2, 32'hDEAD_BEEF, {32'h24, 32'h0001_01B3});
    check("bypass_rs1", out_bus[111:80], 32'hDEAD_BEEF);
    check("bypass_rd", out_bus[15:11], 5'd3);

    // writes to x0 are dropped
    cycle(0, 0, 1, 1, 5'd0, 32'h1234_5678, 0);
    cycle(0, 1, 1, 0, 0, 0, {32'h28, 32'h0000_0033});
    check("x0_rs1", out_bus[111:80], 32'd0);
    check("x0_rs2", out_bus[79:48], 32'd0);
    check("x0_reg_we", out_bus[6], 1'b0);

    cycle(0, 1, 1, 0, 0, 0, {32'h2C, 32'hFFFF_FFFF});
    check("illegal_flags", out_bus[6:0], 7'b0000011);
    cycle(0, 1, 1, 0, 0, 0, {32'h30, 32'hFE00_0EE3});
    check("beq_branch", out_bus[3], 1'b1);
    check("beq_imm", out_bus[47:16], 32'hFFFF_FFFC);

    // fill registers, then reset while holding a stalled output
    for (int i = 1; i < 32; i++) cycle(0, 0, 1, 1, 5'(i), $urandom | 32'h1, 0);
    cycle(0, 1, 1, 0, 0, 0, {32'h34, 32'h0000_0093});
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 5'd7, 32'h5555_AAAA, {32'h38, 32'h0000_0093});
    check("rst_out_valid", {143'd0, out_valid}, 144'd0);
    check("rst_out_bus", out_bus, 144'd0);
    check("rst_in_ready", {143'd0, in_ready}, {143'd0, 1'b1});
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      cycle(0, 1, 1, 0, 0, 0, {32'h100 + 32'(i), 7'd0, r, r, 3'd0, 5'd0, 7'h33});
      check("rst_reg_rs1", out_bus[111:80], 32'd0);
      check("rst_reg_rs2", out_bus[79:48], 32'd0);
    end

    for (int n = 0; n < 3000; n++) begin
      bit rst;
      rst = ($urandom_range(0, 199) == 0);
      inst = rand_inst();
      cycle(rst, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom, {$urandom, inst});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
